// File: rtl/c1_bus_frontend.sv
// c1_bus_frontend
//
// Slave-side front end of the CPU-cache C1 bus. It collects the two-tick C1
// request into one parallel request for the cache core, using a valid/ready
// handshake. It then returns the core's response on the shared tri-state
// command/data lines. A READ32 response takes two ticks, low word first.
//
// Ports
//   clk         in     rising-edge clock for all state
//   reset       in     synchronous, active-high reset
//   address     in     C1 address lines: tag+set on tick A, offset in low bits on tick B
//   data        inout  C1 data lines: write data from the CPU, read data back to it
//   command     inout  C1 command lines: op code from the CPU, NOP/RESP back to it
//   req_valid   out    request pending to the cache core
//   req_ready   in     cache core accepts the request
//   req_op      out    captured command code
//   req_addr    out    {tag+set, offset}
//   req_wdata   out    {hi,lo} for WRITE32, {0,lo} otherwise (WRITE8 keeps only lo[7:0])
//   resp_valid  in     cache core response available
//   resp_rdata  in     read data from the core, zero-extended for READ8/16
//   proto_err   out    sticky protocol-violation flag
//
// Build option
//   C1_FRONTEND_CHECK_EN  when defined, enables the bus protocol checker that
//                         drives proto_err. When undefined, proto_err is tied low.
//
// State table
//   IDLE  | bus released, waiting for tick A (command 1..7)
//   ADDR2 | tick B: capture offset and, for WRITE32, the high data word
//   ISSUE | req_valid high, waiting for req_ready
//   WAIT  | request accepted, driving NOP until resp_valid
//   RESP1 | driving RESP, low read word for reads
//   RESP2 | READ32 only: driving RESP plus the high read word
module c1_bus_frontend #(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_OFFSET_SIZE = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
  inout  wire  [BUS_SIZE-1:0]                        data,
  inout  wire  [2:0]                                 command,
  output logic                                       req_valid,
  input  logic                                       req_ready,
  output logic [2:0]                                 req_op,
  output logic [MEM_ADDR_SIZE-1:0]                   req_addr,
  output logic [2*BUS_SIZE-1:0]                      req_wdata,
  input  logic                                       resp_valid,
  input  logic [2*BUS_SIZE-1:0]                      resp_rdata,
  output logic                                       proto_err
);

  localparam int TS_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_READ8   = 3'd1;
  localparam logic [2:0] CMD_READ16  = 3'd2;
  localparam logic [2:0] CMD_READ32  = 3'd3;
  localparam logic [2:0] CMD_WRITE8  = 3'd5;
  localparam logic [2:0] CMD_WRITE32 = 3'd7;
  localparam logic [2:0] CMD_RESP    = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR2 = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP1 = 3'd4,
    RESP2 = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [2:0]               op_q;
  logic [TS_W-1:0]          tagset_q;
  logic [CACHE_OFFSET_SIZE-1:0] offset_q;
  logic [BUS_SIZE-1:0]      lo_q, hi_q;
  logic [2*BUS_SIZE-1:0]    rdata_q;

  logic                     cmd_start;
  logic                     rdata_cap;
  logic                     is_read;
  logic                     cmd_oe, data_oe;
  logic [2:0]               cmd_out;
  logic [BUS_SIZE-1:0]      data_out;

  // An X or Z command compares unknown, so it never starts a transaction.
  assign cmd_start = (command != CMD_NOP);
  assign is_read   = (op_q == CMD_READ8) || (op_q == CMD_READ16) || (op_q == CMD_READ32);
  assign rdata_cap = ((state_q == ISSUE) && req_ready && resp_valid) ||
                     ((state_q == WAIT) && resp_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      tagset_q <= '0;
      offset_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && cmd_start) begin
        op_q     <= command;
        tagset_q <= address;
        lo_q     <= (command == CMD_WRITE8) ? {{(BUS_SIZE-8){1'b0}}, data[7:0]} : data;
        // Clearing hi here gives {0,lo} for every op except WRITE32.
        hi_q     <= '0;
      end
      if (state_q == ADDR2) begin
        offset_q <= address[CACHE_OFFSET_SIZE-1:0];
        if (op_q == CMD_WRITE32) hi_q <= data;
      end
      if (rdata_cap) rdata_q <= resp_rdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_oe   = 1'b0;
    cmd_out  = CMD_NOP;
    data_oe  = 1'b0;
    data_out = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_start) state_d = ADDR2;
      end
      ADDR2: begin
        state_d = ISSUE;
      end
      ISSUE: begin
        if (req_ready) state_d = resp_valid ? RESP1 : WAIT;
      end
      WAIT: begin
        cmd_oe = 1'b1;
        if (resp_valid) state_d = RESP1;
      end
      RESP1: begin
        cmd_oe  = 1'b1;
        cmd_out = CMD_RESP;
        if (is_read) begin
          data_oe  = 1'b1;
          data_out = (op_q == CMD_READ8) ? {{(BUS_SIZE-8){1'b0}}, rdata_q[7:0]}
                                         : rdata_q[BUS_SIZE-1:0];
        end
        state_d = (op_q == CMD_READ32) ? RESP2 : IDLE;
      end
      RESP2: begin
        cmd_oe   = 1'b1;
        cmd_out  = CMD_RESP;
        data_oe  = 1'b1;
        data_out = rdata_q[2*BUS_SIZE-1:BUS_SIZE];
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign command = cmd_oe  ? cmd_out  : {3{1'bz}};
  assign data    = data_oe ? data_out : {BUS_SIZE{1'bz}};

  assign req_valid = (state_q == ISSUE);
  assign req_op    = op_q;
  assign req_addr  = {tagset_q, offset_q};
  assign req_wdata = {hi_q, lo_q};

`ifdef C1_FRONTEND_CHECK_EN
  logic err_d, err_q;

  always_comb begin
    err_d = 1'b0;
    unique case (state_q)
      IDLE:    err_d = cmd_start && ((^address) === 1'bx);
      // On tick B the CPU may only release the command lines or repeat the op.
      ADDR2:   err_d = (command != CMD_NOP) && (command != op_q);
      ISSUE:   err_d = (command != CMD_NOP);
      // While we drive NOP, any other value is contention. In a four-state
      // model a fight shows up as X, so the case-inequality is needed here.
      WAIT:    err_d = (command !== CMD_NOP);
      default: err_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      err_q <= 1'b0;
    else if (err_d) err_q <= 1'b1;
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_c1_bus_frontend.sv
// Directed bench for c1_bus_frontend.
// The CPU side drives the shared lines through its own tri-state drivers.
// The command lines are pulled low and the data lines are pulled high.
// As a result, a released command line reads as 0 and a released data bus
// reads as 16'hFFFF.
module tb_c1_bus_frontend;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] address;
  tri1  [15:0] data;
  tri0  [2:0]  command;
  logic        req_valid, req_ready, resp_valid, proto_err;
  logic [2:0]  req_op;
  logic [18:0] req_addr;
  logic [31:0] req_wdata, resp_rdata;

  logic        cpu_cmd_oe, cpu_data_oe;
  logic [2:0]  cpu_cmd;
  logic [15:0] cpu_data;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef C1_FRONTEND_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  localparam logic [15:0] DATA_Z = 16'hFFFF;
  localparam logic [2:0]  CMD_Z  = 3'd0;

  assign command = cpu_cmd_oe  ? cpu_cmd  : 3'bzzz;
  assign data    = cpu_data_oe ? cpu_data : 16'hzzzz;

  always #5 clk = ~clk;

  c1_bus_frontend dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .data       (data),
    .command    (command),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .proto_err  (proto_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_a(input logic [2:0] op, input logic [14:0] ts,
                        input logic drive_data, input logic [15:0] d);
    cpu_cmd_oe  = 1'b1;
    cpu_cmd     = op;
    address     = ts;
    cpu_data_oe = drive_data;
    cpu_data    = d;
  endtask

  task automatic tick_b(input logic [3:0] off, input logic drive_data, input logic [15:0] d);
    cpu_cmd_oe  = 1'b0;
    address     = {11'd0, off};
    cpu_data_oe = drive_data;
    cpu_data    = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    cpu_cmd_oe  = 1'b0;
    cpu_cmd     = 3'd0;
    cpu_data_oe = 1'b0;
    cpu_data    = 16'd0;
    address     = 15'd0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = 32'd0;
    step();
    step();
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_op",    req_op,    0);
    chk("rst_req_addr",  req_addr,  0);
    chk("rst_req_wdata", req_wdata, 0);
    chk("rst_command",   command,   CMD_Z);
    chk("rst_data",      data,      DATA_Z);
    chk("rst_proto_err", proto_err, 0);
    reset = 1'b0;
    step();

    // READ8 0x000E0, response in the handshake cycle
    tick_a(3'd1, 15'h000E, 1'b0, 16'h0);
    step();
    chk("r8_addr2_req_valid", req_valid, 0);
    tick_b(4'h0, 1'b0, 16'h0);
    req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = 32'h000000A5;
    step();
    chk("r8_req_valid", req_valid, 1);
    chk("r8_req_op",    req_op,    1);
    chk("r8_req_addr",  req_addr,  19'h000E0);
    chk("r8_turn_cmd",  command,   CMD_Z);
    chk("r8_turn_data", data,      DATA_Z);
    step();
    req_ready = 1'b0; resp_valid = 1'b0;
    chk("r8_resp_cmd",  command,   3'd7);
    chk("r8_resp_data", data,      16'h00A5);
    chk("r8_valid_drop", req_valid, 0);
    step();
    chk("r8_idle_cmd",  command,   CMD_Z);
    chk("r8_idle_data", data,      DATA_Z);

    // WRITE32 0x000E0, data 0x5555 / 0xAAAA, response 3 cycles after handshake
    tick_a(3'd7, 15'h000E, 1'b1, 16'h5555);
    step();
    tick_b(4'h0, 1'b1, 16'hAAAA);
    step();
    cpu_data_oe = 1'b0;
    chk("w32_req_op",    req_op,    7);
    chk("w32_req_addr",  req_addr,  19'h000E0);
    chk("w32_req_wdata", req_wdata, 32'hAAAA5555);
    chk("w32_req_valid", req_valid, 1);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("w32_wait_cmd",   command,   3'd0);
      chk("w32_wait_data",  data,      DATA_Z);
      chk("w32_wait_valid", req_valid, 0);
      if (i == 2) resp_valid = 1'b1;
      step();
    end
    resp_valid = 1'b0;
    chk("w32_resp_cmd",  command, 3'd7);
    chk("w32_resp_data", data,    DATA_Z);
    step();
    chk("w32_idle_cmd",  command, CMD_Z);

    // READ32 0x002E0 issued right after the write completes
    tick_a(3'd3, 15'h002E, 1'b0, 16'h0);
    step();
    tick_b(4'h0, 1'b0, 16'h0);
    req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = 32'hF0F00F0F;
    step();
    chk("r32_req_op",   req_op,   3);
    chk("r32_req_addr", req_addr, 19'h002E0);
    step();
    req_ready = 1'b0; resp_valid = 1'b0;
    chk("r32_lo_cmd",  command, 3'd7);
    chk("r32_lo_data", data,    16'h0F0F);
    step();
    chk("r32_hi_cmd",  command, 3'd7);
    chk("r32_hi_data", data,    16'hF0F0);
    step();
    chk("r32_idle_cmd",  command, CMD_Z);
    chk("r32_idle_data", data,    DATA_Z);

    // INV_LINE 0x00110 with req_ready held low
    tick_a(3'd4, 15'h0011, 1'b0, 16'h0);
    step();
    tick_b(4'h0, 1'b0, 16'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("inv_req_valid", req_valid, 1);
      chk("inv_req_addr",  req_addr,  19'h00110);
      chk("inv_req_op",    req_op,    4);
      chk("inv_hold_cmd",  command,   CMD_Z);
      if (i == 4) begin
        req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = 32'h0;
      end
      step();
    end
    req_ready = 1'b0; resp_valid = 1'b0;
    chk("inv_resp_cmd",  command,   3'd7);
    chk("inv_resp_data", data,      DATA_Z);
    chk("inv_valid_drop", req_valid, 0);
    step();
    chk("inv_idle_cmd",  command,   CMD_Z);

    // READ32 aborted by reset during RESP1, then READ16 0x00344
    tick_a(3'd3, 15'h002E, 1'b0, 16'h0);
    step();
    tick_b(4'h0, 1'b0, 16'h0);
    req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = 32'h12345678;
    step();
    step();
    req_ready = 1'b0; resp_valid = 1'b0;
    chk("abort_resp1_data", data, 16'h5678);
    reset = 1'b1;
    step();
    chk("abort_req_valid", req_valid, 0);
    chk("abort_req_op",    req_op,    0);
    chk("abort_req_addr",  req_addr,  0);
    chk("abort_req_wdata", req_wdata, 0);
    chk("abort_command",   command,   CMD_Z);
    chk("abort_data",      data,      DATA_Z);
    chk("abort_proto_err", proto_err, 0);
    reset = 1'b0;
    step();
    chk("abort_no_resp2_cmd",  command, CMD_Z);
    chk("abort_no_resp2_data", data,    DATA_Z);
    tick_a(3'd2, 15'h0034, 1'b0, 16'h0);
    step();
    tick_b(4'h4, 1'b0, 16'h0);
    req_ready = 1'b1;
    step();
    chk("r16_req_op",   req_op,   2);
    chk("r16_req_addr", req_addr, 19'h00344);
    step();
    req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h0000BEEF;
    chk("r16_wait_cmd", command, 3'd0);
    step();
    resp_valid = 1'b0;
    chk("r16_resp_cmd",  command, 3'd7);
    chk("r16_resp_data", data,    16'hBEEF);
    step();
    chk("r16_idle_data", data,    DATA_Z);
    chk("r16_proto_err", proto_err, 0);

    // WRITE8 0x00455, the CPU fights the NOP during WAIT
    tick_a(3'd5, 15'h0045, 1'b1, 16'h12AB);
    step();
    tick_b(4'h5, 1'b0, 16'h0);
    step();
    chk("w8_req_wdata", req_wdata, 32'h000000AB);
    chk("w8_req_addr",  req_addr,  19'h00455);
    chk("w8_req_op",    req_op,    5);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("w8_err_before", proto_err, 0);
    cpu_cmd_oe = 1'b1; cpu_cmd = 3'd2;
    step();
    cpu_cmd_oe = 1'b0;
    chk("w8_err_set", proto_err, ERR_EXP);
    resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    chk("w8_resp_cmd",   command,   3'd7);
    chk("w8_err_sticky", proto_err, ERR_EXP);
    step();
    chk("w8_err_idle",   proto_err, ERR_EXP);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("w8_err_cleared", proto_err, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/c1_bus_frontend.md
# c1_bus_frontend

Synthesizable slave-side front end of the CPU–cache C1 bus: sits directly downstream of the CPU model and upstream of the cache core. Deserializes the two-tick C1 request (tag+set, then offset), presents it to the cache core as one parallel request with a valid/ready handshake, and serializes the response back onto the shared tri-state `command`/`data` lines, including the two-tick READ32 data return.

## Interface
- `MEM_ADDR_SIZE`, 19, full byte address width
- `BUS_SIZE`, 16, C1 data bus width
- `CACHE_OFFSET_SIZE`, 4, line-offset bits

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `address`  in  MEM_ADDR_SIZE-CACHE_OFFSET_SIZE  C1 address lines (tag+set on tick A, offset in low 4 bits on tick B)
- `data`  inout  BUS_SIZE  C1 data lines
- `command`  inout  3  C1 command lines (NOP=0, READ8=1, READ16=2, READ32=3, INV_LINE=4, WRITE8=5, WRITE16=6, WRITE32/RESP=7)
- `req_valid`  out  1  request pending to cache core
- `req_ready`  in  1  core accepts request
- `req_op`  out  3  captured command code
- `req_addr`  out  MEM_ADDR_SIZE  {tag+set, offset}
- `req_wdata`  out  2*BUS_SIZE  write data; {hi,lo} for WRITE32, {16'b0,lo} otherwise
- `resp_valid`  in  1  core response ready
- `resp_rdata`  in  2*BUS_SIZE  read data, zero-extended for READ8/16
- `proto_err`  out  1  sticky protocol-violation flag

## Operation
- States: IDLE, ADDR2, ISSUE, WAIT, RESP1, RESP2.
- IDLE: sample `command`; codes 1–7 start a transaction: latch op, `address` as tag+set, `data` as low word -> ADDR2. Codes 0, X or Z ignored.
- ADDR2: latch `address[3:0]` as offset; for WRITE32 latch `data` as high word -> ISSUE.
- ISSUE: `req_valid`=1, fields stable. Handshake on `req_valid && req_ready`. If `resp_valid` is also high in the handshake cycle -> RESP1 directly (capture `resp_rdata`); else -> WAIT.
- WAIT: drive `command`=NOP; `resp_valid` -> capture `resp_rdata`, go RESP1. `resp_valid` outside ISSUE/WAIT ignored.
- RESP1: drive `command`=7; reads drive `data`=rdata[15:0] (READ8: {8'b0, rdata[7:0]}); writes/INV leave `data` at Z. READ32 -> RESP2, else -> IDLE.
- RESP2: drive `command`=7, `data`=rdata[31:16] -> IDLE.
- Write8 uses `data[7:0]`, Write16 `data[15:0]`; upper bits of `req_wdata` zero.
- Outside RESP1/RESP2/WAIT and the ISSUE drive window, `command` and `data` are Z.

## Timing
- Tick A sampled at posedge N, tick B at N+1; `req_valid` high from N+1.
- Turnaround: no bus drive during cycle N+1..N+2; earliest drive of `command` from posedge N+2.
- Minimum latency: `req_ready`=`resp_valid`=1 at posedge N+2 -> `command`=7 valid N+2..N+3; READ32 high word N+3..N+4; bus Z from N+4.
- `req_*` outputs hold unchanged from N+1 until handshake; `req_valid` drops the cycle after handshake.
- Back-to-back: IDLE after last response tick accepts a new tick A at the very next edge.
- Reset (any state, incl. mid-response): next edge -> IDLE, `req_valid`=0, `req_op`=0, `req_addr`=0, `req_wdata`=0, `command`=Z, `data`=Z, `proto_err`=0. Aborted transaction is dropped, not replayed.

## Configuration
- `C1_FRONTEND_CHECK_EN` defined: `proto_err` sets (sticky until reset) when, in ADDR2, `command` is not Z/unchanged-op, or when, in ISSUE/WAIT, `command` resolves to non-Z while the slave is not driving it (CPU contention), or `address` is X in IDLE with a valid command.
- Undefined: no checking logic; `proto_err` tied 0.

## Test plan
- READ8 addr 0x000E0 (tag+set 0x000E, offset 0), core returns 0x000000A5 same cycle as handshake -> `req_op`=1, `req_addr`=0x000E0; `command`=7, `data`=0x00A5 for one cycle at N+2, then Z.
- WRITE32 addr 0x000E0, data ticks 0x5555 then 0xAAAA, core `resp_valid` 3 cycles after handshake -> `req_wdata`=0xAAAA5555; `command`=NOP for 3 cycles, then 7 once, `data` stays Z.
- READ32 addr 0x002E0, rdata 0xF0F00F0F -> `data`=0x0F0F then 0xF0F0 on consecutive cycles with `command`=7, then both lines Z.
- INV_LINE addr 0x00110, `req_ready` held low 5 cycles -> `req_valid` and `req_addr`=0x00110 stable 5 cycles; single `command`=7 response.
- `reset` pulsed during RESP1 of a READ32 -> next edge all outputs at reset values, RESP2 never occurs; next READ16 completes normally.
- With `C1_FRONTEND_CHECK_EN`: bench drives `command`=2 during WAIT -> `proto_err`=1 and stays 1 until `reset`; without macro -> `proto_err`=0.
